axis_pattern_source: RTL and testbench

- Self-contained AXI-Stream master that produces 8-bit pixel bytes for one or more video frames, with TLAST on the final byte of each frame.
- Sits directly upstream of the pixel data controller, on its S_AXIS slave port. It stands in for the PS DMA during bring-up and in regression benches, and replaces free-running random stimulus with deterministic, frame-aligned patterns.

---
 rtl/axis_pattern_source.sv | 187 ++++++++++++++++++
 tb/tb_axis_pattern_source.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_source.sv
// axis_pattern_source: AXI-Stream master emitting deterministic, frame-aligned 8-bit test patterns.
// Define AXIS_PATTERN_LFSR_EN to build the LFSR pattern for MODE=3; otherwise MODE=3 is a ramp.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for START
// STREAM | presenting the beats of a frame, held until accepted

module axis_pattern_source #(
    parameter int H_PIXELS        = 640,
    parameter int V_LINES         = 480,
    parameter int BYTES_PER_PIXEL = 2
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       START,
    input  logic [1:0] MODE,
    input  logic       CONTINUOUS,
    output logic [7:0] M_AXIS_DATA,
    output logic       M_AXIS_VALID,
    input  logic       M_AXIS_READY,
    output logic       M_AXIS_LAST,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [1:0]  B_MAX   = 2'(BYTES_PER_PIXEL - 1);
    localparam logic [15:0] X_MAX   = 16'(H_PIXELS - 1);
    localparam logic [15:0] Y_MAX   = 16'(V_LINES - 1);
    localparam logic [15:0] BAR_DIV = 16'(H_PIXELS / 8);

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  b_q, b_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        start_frame, step, accept;

`ifdef AXIS_PATTERN_LFSR_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    logic [7:0] lfsr_q, lfsr_d;
`endif

    assign accept = valid_q & M_AXIS_READY;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        b_d         = b_q;
        x_d         = x_q;
        y_d         = y_q;
        n_d         = n_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done_d      = 1'b0;
        start_frame = 1'b0;
        step        = 1'b0;
`ifdef AXIS_PATTERN_LFSR_EN
        lfsr_d      = lfsr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d     = ST_STREAM;
                    start_frame = 1'b1;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (last_q) begin
                        done_d = 1'b1;
                        if (CONTINUOUS) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_frame) begin
            mode_d = MODE;
            b_d    = '0;
            x_d    = '0;
            y_d    = '0;
            n_d    = '0;
`ifdef AXIS_PATTERN_LFSR_EN
            lfsr_d = LFSR_SEED;
`endif
        end else if (step) begin
            n_d = n_q + 8'd1;
`ifdef AXIS_PATTERN_LFSR_EN
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
            if (b_q != B_MAX) begin
                b_d = b_q + 2'd1;
            end else begin
                b_d = '0;
                if (x_q != X_MAX) begin
                    x_d = x_q + 16'd1;
                end else begin
                    x_d = '0;
                    y_d = y_q + 16'd1;
                end
            end
        end

        // Outputs are registered, so the pattern is computed from the next counter values.
        if (start_frame || step) begin
            valid_d = 1'b1;
            last_d  = (b_d == B_MAX) && (x_d == X_MAX) && (y_d == Y_MAX);
            case (mode_d)
                2'd1:    data_d = {3'(x_d / BAR_DIV), 3'b000, b_d};
                2'd2:    data_d = (x_d[3] ^ y_d[3]) ? 8'hFF : 8'h00;
`ifdef AXIS_PATTERN_LFSR_EN
                2'd3:    data_d = lfsr_d;
`endif
                default: data_d = n_d;
            endcase
        end
    end

    assign busy_d = (state_d == ST_STREAM);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            b_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            b_q     <= b_d;
            x_q     <= x_d;
            y_q     <= y_d;
            n_q     <= n_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef AXIS_PATTERN_LFSR_EN
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    assign M_AXIS_DATA  = data_q;
    assign M_AXIS_VALID = valid_q;
    assign M_AXIS_LAST  = last_q;
    assign BUSY         = busy_q;
    assign FRAME_DONE   = done_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// tb_axis_pattern_source: frame-level reference model plus per-cycle compare for axis_pattern_source.
// Directed frames pin the model with literal bytes; a randomized phase stresses READY/START/MODE/reset.

module tb_axis_pattern_source;

    localparam int H   = 16;
    localparam int V   = 10;
    localparam int BPP = 2;
    localparam int N   = H * V * BPP;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       START = 1'b0;
    logic [1:0] MODE = 2'd0;
    logic       CONTINUOUS = 1'b0;
    logic       READY = 1'b0;
    logic [7:0] M_AXIS_DATA;
    logic       M_AXIS_VALID;
    logic       M_AXIS_LAST;
    logic       BUSY;
    logic       FRAME_DONE;

    axis_pattern_source #(
        .H_PIXELS(H), .V_LINES(V), .BYTES_PER_PIXEL(BPP)
    ) dut (
        .i_CLK(clk), .i_RST(rst), .START(START), .MODE(MODE), .CONTINUOUS(CONTINUOUS),
        .M_AXIS_DATA(M_AXIS_DATA), .M_AXIS_VALID(M_AXIS_VALID), .M_AXIS_READY(READY),
        .M_AXIS_LAST(M_AXIS_LAST), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: whole-frame byte list plus the index of the beat on offer.
    logic [7:0] exp_data [N];
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    int         m_idx = 0;

    logic [7:0] acc_d[$];
    bit         acc_l[$];
    int         acc_c[$];
    int         done_cnt = 0;
    int         cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic build_frame(input logic [1:0] mode);
        logic [7:0] lf;
        lf = 8'hA5;
        for (int k = 0; k < N; k++) begin
            int bb, p, xx, yy;
            bb = k % BPP;
            p  = k / BPP;
            xx = p % H;
            yy = p / H;
            case (mode)
                2'd1: exp_data[k] = 8'((xx / (H / 8)) * 32 + bb);
                2'd2: exp_data[k] = ((((xx / 8) + (yy / 8)) % 2) == 1) ? 8'hFF : 8'h00;
`ifdef AXIS_PATTERN_LFSR_EN
                2'd3: exp_data[k] = lf;
`endif
                default: exp_data[k] = 8'(k % 256);
            endcase
            lf = {lf[6:0], ^(lf & 8'hB8)};
        end
    endtask

    // Model update and acceptance log, on the active edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (M_AXIS_VALID && READY) begin
            acc_d.push_back(M_AXIS_DATA);
            acc_l.push_back(M_AXIS_LAST);
            acc_c.push_back(cyc);
        end
        if (FRAME_DONE) done_cnt++;
        m_done = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_idx    = 0;
        end else if (!m_active) begin
            if (START) begin
                build_frame(MODE);
                m_active = 1'b1;
                m_idx    = 0;
            end
        end else if (READY) begin
            if (m_idx == N - 1) begin
                m_done = 1'b1;
                if (CONTINUOUS) begin
                    build_frame(MODE);
                    m_idx = 0;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_idx++;
            end
        end
    end

    // Per-cycle compare on the inactive edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("valid", 32'(M_AXIS_VALID), 32'(m_active));
            chk("busy", 32'(BUSY), 32'(m_active));
            chk("frame_done", 32'(FRAME_DONE), 32'(m_done));
            if (m_active) begin
                chk("data", 32'(M_AXIS_DATA), 32'(exp_data[m_idx]));
                chk("last", 32'(M_AXIS_LAST), 32'(m_idx == N - 1));
            end
        end
    end

    task automatic reset_check(input string tag);
        chk({tag, "_valid"}, 32'(M_AXIS_VALID), 32'd0);
        chk({tag, "_last"}, 32'(M_AXIS_LAST), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_data"}, 32'(M_AXIS_DATA), 32'd0);
        chk({tag, "_done"}, 32'(FRAME_DONE), 32'd0);
    endtask

    // One frame (two when 'two' is set) from IDLE back to IDLE; bp selects READY 1,0,0,1,0,1...
    task automatic run_frame(input logic [1:0] mode, input bit bp, input bit two);
        acc_d.delete();
        acc_l.delete();
        acc_c.delete();
        @(negedge clk);
        MODE = mode;
        CONTINUOUS = two;
        READY = 1'b1;
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            if (m_done) CONTINUOUS = 1'b0;
            if (bp) READY = ((t % 6) == 0) || ((t % 6) == 3) || ((t % 6) == 5);
            if (t == 10 && !two) begin
                MODE  = mode ^ 2'b10;
                START = 1'b1;
            end else begin
                START = 1'b0;
            end
            @(negedge clk);
            if (!m_active) break;
        end
        chk("frame_timeout", 32'(m_active), 32'd0);
        READY = 1'b1;
        START = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int lastcnt;
    int dsnap;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_check("por");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        dsnap = done_cnt;
        run_frame(2'd0, 1'b0, 1'b0);
        chk("ramp_count", 32'(acc_d.size()), 32'(N));
        chk("ramp_done", 32'(done_cnt - dsnap), 32'd1);
        if (acc_d.size() == N) begin
            chk("ramp_b0", 32'(acc_d[0]), 32'h00);
            chk("ramp_b1", 32'(acc_d[1]), 32'h01);
            chk("ramp_b2", 32'(acc_d[2]), 32'h02);
            chk("ramp_b255", 32'(acc_d[255]), 32'hFF);
            chk("ramp_wrap", 32'(acc_d[256]), 32'h00);
            chk("ramp_lastbyte", 32'(acc_d[N-1]), 32'h3F);
            chk("ramp_lastflag", 32'(acc_l[N-1]), 32'd1);
            chk("ramp_span", 32'(acc_c[N-1] - acc_c[0]), 32'(N - 1));
            lastcnt = 0;
            foreach (acc_l[i]) if (acc_l[i]) lastcnt++;
            chk("ramp_lastcnt", 32'(lastcnt), 32'd1);
        end

        run_frame(2'd0, 1'b1, 1'b0);
        chk("bp_count", 32'(acc_d.size()), 32'(N));
        if (acc_d.size() == N)
            foreach (acc_d[i]) chk("bp_seq", 32'(acc_d[i]), 32'(i % 256));

        run_frame(2'd1, 1'b0, 1'b0);
        if (acc_d.size() == N) begin
            chk("bars_x2b1", 32'(acc_d[5]), 32'h21);
            chk("bars_x15b0", 32'(acc_d[30]), 32'hE0);
        end

        run_frame(2'd2, 1'b0, 1'b0);
        if (acc_d.size() == N) begin
            chk("chk_x0y0", 32'(acc_d[0]), 32'h00);
            chk("chk_x8y0", 32'(acc_d[16]), 32'hFF);
            chk("chk_x8y8", 32'(acc_d[272]), 32'h00);
            chk("chk_x0y8", 32'(acc_d[256]), 32'hFF);
        end

        for (int r = 0; r < 2; r++) begin
            run_frame(2'd3, 1'b0, 1'b0);
            if (acc_d.size() == N) begin
`ifdef AXIS_PATTERN_LFSR_EN
                chk("lfsr_b0", 32'(acc_d[0]), 32'hA5);
                chk("lfsr_b1", 32'(acc_d[1]), 32'h4A);
                chk("lfsr_b2", 32'(acc_d[2]), 32'h95);
`else
                chk("lfsr_b0", 32'(acc_d[0]), 32'h00);
                chk("lfsr_b1", 32'(acc_d[1]), 32'h01);
                chk("lfsr_b2", 32'(acc_d[2]), 32'h02);
`endif
            end
        end

        dsnap = done_cnt;
        run_frame(2'd0, 1'b0, 1'b1);
        chk("cont_count", 32'(acc_d.size()), 32'(2 * N));
        chk("cont_done", 32'(done_cnt - dsnap), 32'd2);
        if (acc_d.size() == 2 * N) begin
            chk("cont_span", 32'(acc_c[2*N-1] - acc_c[0]), 32'(2 * N - 1));
            chk("cont_restart", 32'(acc_d[N]), 32'h00);
            chk("cont_f1last", 32'(acc_l[N-1]), 32'd1);
        end

        // Reset in the middle of a frame.
        @(negedge clk);
        MODE = 2'd0; READY = 1'b1; START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        repeat (50) @(negedge clk);
        dsnap = done_cnt;
        #2 rst = 1'b1;
        #1 reset_check("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_nodone", 32'(done_cnt - dsnap), 32'd0);
        chk("midrst_idle", 32'(M_AXIS_VALID), 32'd0);

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            READY      = ($urandom_range(0, 3) != 0);
            START      = ($urandom_range(0, 15) == 0);
            MODE       = 2'($urandom_range(0, 3));
            CONTINUOUS = ($urandom_range(0, 2) == 0);
            if (c == 1700) begin
                #2 rst = 1'b1;
                #1 reset_check("rnd_rst");
            end
            if (c == 1703) rst = 1'b0;
            @(negedge clk);
        end
        START = 1'b0;
        CONTINUOUS = 1'b0;
        READY = 1'b1;
        for (int t = 0; t < 2000 && m_active; t++) @(negedge clk);
        chk("drain_timeout", 32'(m_active), 32'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
